benes_perm_ctrl: RTL and testbench



---
 rtl/benes_perm_ctrl.sv | 92 +++++++++
 tb/tb_benes_perm_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/benes_perm_ctrl.sv
// Issue/config controller ahead of the Benes network: registers input vectors, tracks
// in-flight validity and swaps switch settings only once the network has drained.
module benes_perm_ctrl #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned SIZE       = 32,
    parameter int unsigned SWITCH_NUM = 16,
    parameter int unsigned STAGE_NUM  = 9,
    parameter int unsigned BUFFER_NUM = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_WIDTH-1:0]        in_vec         [0:SIZE-1],
    input  logic                         cfg_we,
    input  logic [$clog2(STAGE_NUM)-1:0] cfg_stage,
    input  logic [SWITCH_NUM-1:0]        cfg_data,
    input  logic                         cfg_commit,
    output logic                         cfg_busy,
    output logic                         cfg_done,
    output logic                         cfg_err,
    output logic [DATA_WIDTH-1:0]        net_i_port     [0:SIZE-1],
    output logic [SWITCH_NUM-1:0]        net_switch_set [0:STAGE_NUM-1],
    output logic                         out_valid
);

    typedef enum logic [1:0] {StRun, StDrain, StCommit} state_e;

    state_e                state_q, state_d;
    logic [BUFFER_NUM:0]   pipe_q;
    logic [SWITCH_NUM-1:0] shadow_q [0:STAGE_NUM-1];
    logic                  cfg_err_q;
    logic                  accept;
    logic                  stage_ok;
    logic                  cfg_write;
    logic                  cfg_bad;

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        cfg_busy = 1'b0;
        cfg_done = 1'b0;
        case (state_q)
            StRun: begin
                in_ready = 1'b1;
                if (cfg_commit) state_d = StDrain;
            end
            StDrain: begin
                cfg_busy = 1'b1;
                if (pipe_q == '0) state_d = StCommit;
            end
            StCommit: begin
                cfg_busy = 1'b1;
                cfg_done = 1'b1;
                state_d  = StRun;
            end
            default: state_d = StRun;
        endcase
    end

    assign accept    = in_valid & in_ready;
    assign stage_ok  = 32'(cfg_stage) < STAGE_NUM;
    assign cfg_write = cfg_we & (state_q == StRun) & stage_ok;
    assign cfg_bad   = cfg_we & ~cfg_write;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StRun;
            pipe_q    <= '0;
            cfg_err_q <= 1'b0;
            for (int s = 0; s < STAGE_NUM; s++) begin
                shadow_q[s]       <= '0;
                net_switch_set[s] <= '0;
            end
            for (int p = 0; p < SIZE; p++) net_i_port[p] <= '0;
        end else begin
            state_q   <= state_d;
            pipe_q    <= {pipe_q[BUFFER_NUM-1:0], accept};
            cfg_err_q <= cfg_bad;
            // Idle cycles feed zeros so the network never sees stale data.
            for (int p = 0; p < SIZE; p++) net_i_port[p] <= accept ? in_vec[p] : '0;
            if (cfg_write) shadow_q[cfg_stage] <= cfg_data;
            if (state_q == StCommit) begin
                for (int s = 0; s < STAGE_NUM; s++) net_switch_set[s] <= shadow_q[s];
            end
        end
    end

    assign out_valid = pipe_q[BUFFER_NUM];
    assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_benes_perm_ctrl.sv
// Directed bench for benes_perm_ctrl: latency, streaming, commit timing, errors, reset.
module tb_benes_perm_ctrl;

    localparam int DW = 64;
    localparam int SZ = 32;
    localparam int SW = 16;
    localparam int SN = 9;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_vec [0:SZ-1];
    logic          cfg_we;
    logic [3:0]    cfg_stage;
    logic [SW-1:0] cfg_data;
    logic          cfg_commit;
    logic          cfg_busy;
    logic          cfg_done;
    logic          cfg_err;
    logic [DW-1:0] net_i_port [0:SZ-1];
    logic [SW-1:0] net_switch_set [0:SN-1];
    logic          out_valid;

    logic [SW-1:0] exp_set [0:SN-1];
    int            n_tests;
    int            n_fail;

    benes_perm_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_vec         (in_vec),
        .cfg_we         (cfg_we),
        .cfg_stage      (cfg_stage),
        .cfg_data       (cfg_data),
        .cfg_commit     (cfg_commit),
        .cfg_busy       (cfg_busy),
        .cfg_done       (cfg_done),
        .cfg_err        (cfg_err),
        .net_i_port     (net_i_port),
        .net_switch_set (net_switch_set),
        .out_valid      (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_vec(input logic [DW-1:0] base);
        for (int i = 0; i < SZ; i++) in_vec[i] = base + DW'(i);
    endtask

    task automatic check_set(input string tag);
        for (int s = 0; s < SN; s++) check_eq(tag, net_switch_set[s], exp_set[s]);
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        rst        = 1'b1;
        in_valid   = 1'b0;
        cfg_we     = 1'b0;
        cfg_stage  = '0;
        cfg_data   = '0;
        cfg_commit = 1'b0;
        set_vec('0);
        for (int s = 0; s < SN; s++) exp_set[s] = '0;
        tick();
        tick();
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_busy", cfg_busy, 0);
        check_eq("rst_done", cfg_done, 0);
        check_eq("rst_err", cfg_err, 0);
        check_eq("rst_net_i", net_i_port[7], 0);
        check_set("rst_switch");
        rst = 1'b0;
        tick();

        // Identity path: single vector i -> i, accepted at relative edge 0
        set_vec('0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check_eq("id_net_i0", net_i_port[0], 0);
        check_eq("id_net_i31", net_i_port[31], 31);
        for (int c = 1; c <= 12; c++) begin
            check_eq($sformatf("id_out_valid_c%0d", c), out_valid, (c == 9) ? 1 : 0);
            tick();
        end
        check_set("id_switch");

        // Streaming: 20 back-to-back vectors at edges 0..19 -> out_valid cycles 9..28
        for (int e = 0; e < 35; e++) begin
            in_valid = (e < 20);
            set_vec(64'h1000 * e);
            if (e < 20) check_eq($sformatf("str_ready_e%0d", e), in_ready, 1);
            tick();
            check_eq($sformatf("str_ov_c%0d", e + 1), out_valid,
                     ((e + 1 >= 9) && (e + 1 <= 28)) ? 1 : 0);
            if (e == 0) check_eq("str_net_i", net_i_port[3], 64'h3);
            if (e == 5) check_eq("str_net_i5", net_i_port[2], 64'h5002);
        end
        in_valid = 1'b0;

        // Commit on an empty pipe
        cfg_we    = 1'b1;
        cfg_stage = 4'd0;
        cfg_data  = 16'hFFFF;
        tick();
        cfg_we     = 1'b0;
        cfg_commit = 1'b1;
        check_eq("ec_ready_pre", in_ready, 1);
        tick();
        cfg_commit = 1'b0;
        check_eq("ec_ready_drain", in_ready, 0);
        check_eq("ec_busy_drain", cfg_busy, 1);
        check_eq("ec_done_drain", cfg_done, 0);
        check_set("ec_switch_drain");
        tick();
        check_eq("ec_ready_commit", in_ready, 0);
        check_eq("ec_busy_commit", cfg_busy, 1);
        check_eq("ec_done_commit", cfg_done, 1);
        check_set("ec_switch_commit");
        tick();
        exp_set[0] = 16'hFFFF;
        check_eq("ec_ready_after", in_ready, 1);
        check_eq("ec_busy_after", cfg_busy, 0);
        check_eq("ec_done_after", cfg_done, 0);
        check_set("ec_switch_after");

        // Commit with 3 vectors in flight; write to stage 1 rides along with the commit
        for (int v = 0; v < 3; v++) begin
            in_valid = 1'b1;
            set_vec(64'h100 * (v + 1));
            if (v == 2) begin
                cfg_commit = 1'b1;
                cfg_we     = 1'b1;
                cfg_stage  = 4'd1;
                cfg_data   = 16'h00A5;
            end
            tick();
        end
        cfg_commit = 1'b0;
        cfg_we     = 1'b0;
        set_vec(64'hDEAD0000);
        for (int r = 1; r <= 13; r++) begin
            if (r == 12) exp_set[1] = 16'h00A5;
            check_eq($sformatf("if_ready_r%0d", r), in_ready, (r >= 12) ? 1 : 0);
            check_eq($sformatf("if_ov_r%0d", r), out_valid, ((r >= 7) && (r <= 9)) ? 1 : 0);
            check_eq($sformatf("if_done_r%0d", r), cfg_done, (r == 11) ? 1 : 0);
            check_eq($sformatf("if_sw0_r%0d", r), net_switch_set[0], 16'hFFFF);
            check_eq($sformatf("if_sw1_r%0d", r), net_switch_set[1], exp_set[1]);
            if (r == 1) check_eq("if_net_i_v3", net_i_port[5], 64'h305);
            else check_eq($sformatf("if_net_i_r%0d", r), net_i_port[5], 0);
            // Keep in_valid high while blocked; drop it before the first RUN edge.
            in_valid = (r <= 11);
            tick();
        end
        in_valid = 1'b0;
        check_set("if_switch_final");

        // Illegal config: out-of-range stage, then a write during DRAIN
        cfg_we    = 1'b1;
        cfg_stage = 4'd9;
        cfg_data  = 16'h1234;
        tick();
        check_eq("ill_err_range", cfg_err, 1);
        cfg_we     = 1'b0;
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
        check_eq("ill_err_clear", cfg_err, 0);
        check_eq("ill_busy", cfg_busy, 1);
        cfg_we    = 1'b1;
        cfg_stage = 4'd2;
        cfg_data  = 16'h5555;
        tick();
        cfg_we = 1'b0;
        check_eq("ill_err_drain", cfg_err, 1);
        check_eq("ill_done", cfg_done, 1);
        tick();
        check_eq("ill_err_end", cfg_err, 0);
        check_eq("ill_ready", in_ready, 1);
        check_set("ill_switch");

        // Reset while draining: commit aborted, everything cleared
        in_valid   = 1'b1;
        set_vec(64'h700);
        cfg_commit = 1'b1;
        cfg_we     = 1'b1;
        cfg_stage  = 4'd3;
        cfg_data   = 16'hBEEF;
        tick();
        in_valid   = 1'b0;
        cfg_commit = 1'b0;
        cfg_we     = 1'b0;
        check_eq("rd_busy_pre", cfg_busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int s = 0; s < SN; s++) exp_set[s] = '0;
        check_eq("rd_ready", in_ready, 1);
        check_eq("rd_out_valid", out_valid, 0);
        check_eq("rd_busy", cfg_busy, 0);
        check_eq("rd_done", cfg_done, 0);
        check_set("rd_switch");
        for (int c = 0; c < 12; c++) begin
            tick();
            check_eq($sformatf("rd_ov_c%0d", c), out_valid, 0);
            check_eq($sformatf("rd_done_c%0d", c), cfg_done, 0);
        end
        // Shadow must have been cleared: a fresh commit yields all-zero settings
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
        tick();
        check_eq("rd_recommit_done", cfg_done, 1);
        tick();
        check_set("rd_recommit_switch");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
